// File: rtl/conv3d_pkg.sv
// conv3d_pkg: shared FSM state type, clog2 helper and the default engine geometry.
package conv3d_pkg;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    HOLD
  } state_e;

  function automatic int clog2(input int value);
    int result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  localparam int DEF_K1     = 3;
  localparam int DEF_K2     = 3;
  localparam int DEF_K3     = 3;
  localparam int DEF_C      = 1;
  localparam int DEF_D      = 8;
  localparam int DEF_H      = 16;
  localparam int DEF_W      = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_OUT_W  = 20;

  localparam int DEF_T     = DEF_K1 * DEF_K2 * DEF_K3 * DEF_C;
  localparam int DEF_NIN   = DEF_D * DEF_H * DEF_W * DEF_C;
  localparam int DEF_OD    = DEF_D - DEF_K1 + 1;
  localparam int DEF_OH    = DEF_H - DEF_K2 + 1;
  localparam int DEF_OW    = DEF_W - DEF_K3 + 1;
  localparam int DEF_NOUT  = DEF_OD * DEF_OH * DEF_OW;
  localparam int DEF_ACC_W = 2 * DEF_DATA_W + clog2(DEF_T);

endpackage

// File: rtl/conv3d_if.sv
// conv3d_if: input voxel stream, kernel bus and output voxel stream of the convolution engine.
interface conv3d_if
  import conv3d_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int KW     = DEF_T * DEF_DATA_W
);
  logic signed [DATA_W-1:0] voxel_in;
  logic                     valid_in;
  logic                     ready_in;
  logic                     last_in;
  logic        [KW-1:0]     kernel;
  logic signed [OUT_W-1:0]  voxel_out;
  logic                     valid_out;
  logic                     out_ready;
  logic                     done;
  logic                     err;

  modport master (
    output voxel_in, valid_in, last_in, kernel, out_ready,
    input  ready_in, voxel_out, valid_out, done, err
  );

  modport slave (
    input  voxel_in, valid_in, last_in, kernel, out_ready,
    output ready_in, voxel_out, valid_out, done, err
  );
endinterface

// File: rtl/conv3d_mac.sv
// conv3d_mac: signed DATA_W x DATA_W multiplier feeding an ACC_W accumulator with clear/enable.
module conv3d_mac
  import conv3d_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  acc_o
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d;

  // Clear folds into the first product so tap 0 needs no extra cycle.
  always_comb begin
    prod  = a_i * b_i;
    acc_d = clr_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/conv3d_engine.sv
// conv3d_engine: buffers a multi-channel voxel volume, then streams its valid-mode 3D convolution.
// Build option CONV3D_SATURATE_EN clamps each result to the OUT_W range instead of wrapping.
module conv3d_engine
  import conv3d_pkg::*;
#(
  parameter int K1     = DEF_K1,
  parameter int K2     = DEF_K2,
  parameter int K3     = DEF_K3,
  parameter int C      = DEF_C,
  parameter int D      = DEF_D,
  parameter int H      = DEF_H,
  parameter int W      = DEF_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input logic     clk,
  input logic     rst,
  conv3d_if.slave bus
);
  localparam int T     = K1 * K2 * K3 * C;
  localparam int NIN   = D * H * W * C;
  localparam int OD    = D - K1 + 1;
  localparam int OH    = H - K2 + 1;
  localparam int OW    = W - K3 + 1;
  localparam int NOUT  = OD * OH * OW;
  localparam int ACC_W = 2 * DATA_W + clog2(T);
  localparam int AW    = (clog2(NIN) > 0) ? clog2(NIN) : 1;
  localparam int TW    = clog2(T + 1);

  state_e                   state_q, state_d;
  logic [AW-1:0]            beatCnt_q, outCnt_q;
  logic [AW-1:0]            od_q, oh_q, ow_q, kd_q, kh_q, kw_q, kc_q;
  logic [TW-1:0]            tapCnt_q;
  logic [T*DATA_W-1:0]      kernel_q;
  logic signed [DATA_W-1:0] coeff_q, rdData_q;
  logic                     macEn_q, macClr_q, done_q, err_q;
  logic signed [DATA_W-1:0] mem [NIN];
  logic [AW-1:0]            rdAddr, ramAddr;
  logic                     accept, lastBeat, lastOut, issue;
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  outVal;

  assign accept   = (state_q == LOAD) && bus.valid_in;
  assign lastBeat = (beatCnt_q == AW'(NIN - 1));
  assign lastOut  = (outCnt_q == AW'(NOUT - 1));
  assign issue    = (state_q == COMPUTE) && (tapCnt_q < TW'(T));
  assign rdAddr   = AW'((((int'(od_q) + int'(kd_q)) * H + int'(oh_q) + int'(kh_q)) * W
                         + int'(ow_q) + int'(kw_q)) * C + int'(kc_q));
  assign ramAddr  = (state_q == LOAD) ? beatCnt_q : rdAddr;

  // Single-port volume buffer: written while loading, read one tap per cycle while computing.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[ramAddr] <= bus.voxel_in;
    end else begin
      rdData_q <= mem[ramAddr];
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.ready_in  = 1'b0;
    bus.valid_out = 1'b0;
    unique case (state_q)
      LOAD: begin
        bus.ready_in = 1'b1;
        if (accept && lastBeat) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (tapCnt_q == TW'(T)) state_d = HOLD;
      end
      HOLD: begin
        bus.valid_out = 1'b1;
        if (bus.out_ready) state_d = lastOut ? LOAD : COMPUTE;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      beatCnt_q <= '0;
      outCnt_q  <= '0;
      od_q      <= '0;
      oh_q      <= '0;
      ow_q      <= '0;
      kd_q      <= '0;
      kh_q      <= '0;
      kw_q      <= '0;
      kc_q      <= '0;
      tapCnt_q  <= '0;
      kernel_q  <= '0;
      coeff_q   <= '0;
      macEn_q   <= 1'b0;
      macClr_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= 1'b0;
      macEn_q  <= 1'b0;
      macClr_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (beatCnt_q == '0) kernel_q <= bus.kernel;
            if (bus.last_in != lastBeat) err_q <= 1'b1;
            beatCnt_q <= lastBeat ? '0 : beatCnt_q + AW'(1);
          end
        end
        COMPUTE: begin
          tapCnt_q <= issue ? tapCnt_q + TW'(1) : '0;
          // The coefficient travels alongside the registered RAM read into the MAC.
          if (issue) begin
            coeff_q  <= kernel_q[int'(tapCnt_q)*DATA_W +: DATA_W];
            macEn_q  <= 1'b1;
            macClr_q <= (tapCnt_q == '0);
            if (kc_q != AW'(C - 1)) begin
              kc_q <= kc_q + AW'(1);
            end else begin
              kc_q <= '0;
              if (kw_q != AW'(K3 - 1)) begin
                kw_q <= kw_q + AW'(1);
              end else begin
                kw_q <= '0;
                if (kh_q != AW'(K2 - 1)) begin
                  kh_q <= kh_q + AW'(1);
                end else begin
                  kh_q <= '0;
                  kd_q <= (kd_q == AW'(K1 - 1)) ? '0 : kd_q + AW'(1);
                end
              end
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            if (lastOut) begin
              outCnt_q <= '0;
              od_q     <= '0;
              oh_q     <= '0;
              ow_q     <= '0;
              done_q   <= 1'b1;
            end else begin
              outCnt_q <= outCnt_q + AW'(1);
              if (ow_q != AW'(OW - 1)) begin
                ow_q <= ow_q + AW'(1);
              end else begin
                ow_q <= '0;
                if (oh_q != AW'(OH - 1)) begin
                  oh_q <= oh_q + AW'(1);
                end else begin
                  oh_q <= '0;
                  od_q <= od_q + AW'(1);
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  conv3d_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr_i(macClr_q),
    .en_i (macEn_q),
    .a_i  (rdData_q),
    .b_i  (coeff_q),
    .acc_o(acc)
  );

`ifdef CONV3D_SATURATE_EN
  localparam int EXT_W = (OUT_W > ACC_W) ? OUT_W : ACC_W;
  localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;
`endif

  always_comb begin
    outVal = OUT_W'(acc);
`ifdef CONV3D_SATURATE_EN
    if (EXT_W'(acc) > OUT_MAX) begin
      outVal = OUT_W'(OUT_MAX);
    end else if (EXT_W'(acc) < OUT_MIN) begin
      outVal = OUT_W'(OUT_MIN);
    end
`endif
  end

  assign bus.voxel_out = outVal;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
